// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared button indices, channel FSM encoding and helpers
package wave_gen_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int NUM_BTN    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchronizer, debounce and press/auto-repeat FSM
module btn_channel
    import wave_gen_pkg::*;
#(
    parameter int DEB_CYC         = 20,
    parameter int REPEAT_DELAY_MS = 5,
    parameter int REPEAT_RATE_MS  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic ms_tick,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(max_int(REPEAT_DELAY_MS, REPEAT_RATE_MS)) + 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_MS - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_MS - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] deb_cnt;
    logic          deb_flip;
    logic          level_next;
    btn_state_t    state, state_next;
    logic [TW-1:0] tick_cnt, tick_cnt_next;
    logic          pulse_next;

    // Level flips when the synchronized input has disagreed for DEB_CYC evaluations.
    assign deb_flip   = (sync_q[1] != level) && (deb_cnt == DEB_LAST);
    assign level_next = level ^ deb_flip;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Debounce counter: runs while input and level disagree, clears on agreement or flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else begin
            level <= level_next;
            if ((sync_q[1] == level) || deb_flip) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Repeat FSM state, tick counter and registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            pulse    <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            pulse    <= pulse_next;
        end
    end

    // Next state works from level_next so the press pulse lands with the new level.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        pulse_next    = 1'b0;
        if (!level_next) begin
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!level) begin
                        pulse_next    = 1'b1;
                        state_next    = ST_DELAY;
                        tick_cnt_next = '0;
                    end
                end
                ST_DELAY: begin
                    if (ms_tick && repeat_en) begin
                        if (tick_cnt == DELAY_LAST) begin
                            pulse_next    = 1'b1;
                            state_next    = ST_REPEAT;
                            tick_cnt_next = '0;
                        end else begin
                            tick_cnt_next = tick_cnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (ms_tick) begin
                        if (tick_cnt == RATE_LAST) begin
                            pulse_next    = 1'b1;
                            tick_cnt_next = '0;
                        end else begin
                            tick_cnt_next = tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    tick_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared ms tick plus five independent button channels
module button_conditioner
    import wave_gen_pkg::*;
#(
    parameter int                 CLK_HZ          = 100000000,
    parameter int                 DEBOUNCE_MS     = 10,
    parameter int                 REPEAT_DELAY_MS = 500,
    parameter int                 REPEAT_RATE_MS  = 100,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b00011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int DEB_CYC  = TICK_DIV * DEBOUNCE_MS;
    localparam int MW       = $clog2(TICK_DIV + 1);
    localparam logic [MW-1:0] MS_LAST = MW'(TICK_DIV - 1);

    logic [MW-1:0] ms_cnt;
    logic          ms_tick;

    // Free-running millisecond divider producing a one-cycle tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else if (ms_cnt == MS_LAST) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b1;
        end else begin
            ms_cnt  <= ms_cnt + 1'b1;
            ms_tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEB_CYC        (DEB_CYC),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (btn_raw[i]),
            .ms_tick  (ms_tick),
            .repeat_en(REPEAT_MASK[i]),
            .level    (btn_level[i]),
            .pulse    (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks against a sample-window reference model
module tb_button_conditioner;
    import wave_gen_pkg::*;

    localparam int DEB   = 20;
    localparam int DIV   = 10;
    localparam int DELAY = 5;
    localparam int RATE  = 2;
    localparam logic [4:0] MASK = 5'b00011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_HZ         (10000),
        .DEBOUNCE_MS    (2),
        .REPEAT_DELAY_MS(DELAY),
        .REPEAT_RATE_MS (RATE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    int checks = 0;
    int failures = 0;
    int abs_cyc = 0;
    int cyc = 0;
    logic [4:0] hist[$];
    logic [4:0] m_level;
    logic [4:0] m_pulse;
    int ticks[5];
    int pulse_cnt[5];
    int first_pulse[5];
    int log1[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, abs_cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        hist.delete();
        for (int k = 0; k < DEB + 2; k++) hist.push_front(5'b0);
        m_level = '0;
        m_pulse = '0;
        for (int b = 0; b < 5; b++) ticks[b] = 0;
    endtask

    // Level flips once the last DEB synchronized samples (raw delayed two edges) all differ from it.
    // Repeat pulses fall on the DELAY-th ms tick after the press, then every RATE-th tick.
    task automatic model_edge(input logic [4:0] raw);
        logic [4:0] nl, np;
        logic tick, all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        hist.push_front(raw);
        if (hist.size() > DEB + 4) void'(hist.pop_back());
        tick = (cyc >= DIV + 1) && ((cyc - 1) % DIV == 0);
        for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (hist[k][b] == m_level[b]) all_diff = 1'b0;
            nl[b] = all_diff ? ~m_level[b] : m_level[b];
            np[b] = 1'b0;
            if (nl[b] && !m_level[b]) begin
                np[b] = 1'b1;
                ticks[b] = 0;
            end else if (nl[b] && tick) begin
                ticks[b]++;
                if (MASK[b] && ticks[b] >= DELAY && (ticks[b] - DELAY) % RATE == 0) np[b] = 1'b1;
            end
        end
        m_level = nl;
        m_pulse = np;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        abs_cyc++;
        model_edge(btn_raw);
        check("level", int'(btn_level), int'(m_level));
        check("pulse", int'(btn_pulse), int'(m_pulse));
        for (int b = 0; b < 5; b++) begin
            if (btn_pulse[b]) begin
                pulse_cnt[b]++;
                if (first_pulse[b] < 0) first_pulse[b] = abs_cyc;
            end
        end
        if (btn_pulse[BTN_DOWN]) log1.push_back(abs_cyc);
    endtask

    task automatic clear_stats();
        for (int b = 0; b < 5; b++) begin
            pulse_cnt[b] = 0;
            first_pulse[b] = -1;
        end
        log1.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int t0;
    int hold;

    initial begin
        model_reset();
        clear_stats();
        #1;
        check("reset_level", int'(btn_level), 0);
        check("reset_pulse", int'(btn_pulse), 0);
        run(3);
        rst_n = 1'b1;
        run(5);

        // Clean press on center
        clear_stats();
        btn_raw[BTN_CENTER] = 1'b1;
        t0 = abs_cyc;
        run(30);
        btn_raw[BTN_CENTER] = 1'b0;
        run(40);
        check("clean_first", first_pulse[BTN_CENTER] - t0, 22);
        check("clean_count", pulse_cnt[BTN_CENTER], 1);

        // Bouncing up button, then a stable high
        clear_stats();
        for (int i = 0; i < 98; i++) begin
            if (i % 7 == 0) btn_raw[BTN_UP] = ~btn_raw[BTN_UP];
            step();
        end
        btn_raw[BTN_UP] = 1'b0;
        run(3);
        check("bounce_none", pulse_cnt[BTN_UP], 0);
        btn_raw[BTN_UP] = 1'b1;
        t0 = abs_cyc;
        run(40);
        check("bounce_first", first_pulse[BTN_UP] - t0, 22);
        btn_raw[BTN_UP] = 1'b0;
        run(40);

        // Auto-repeat on down
        clear_stats();
        btn_raw[BTN_DOWN] = 1'b1;
        t0 = abs_cyc;
        run(200);
        btn_raw[BTN_DOWN] = 1'b0;
        run(40);
        check("rep_first", first_pulse[BTN_DOWN] - t0, 22);
        check("rep_enough", int'(log1.size() >= 4), 1);
        if (log1.size() >= 4) begin
            check("rep_gap_lo", int'(log1[1] - log1[0] >= 40), 1);
            check("rep_gap_hi", int'(log1[1] - log1[0] <= 50), 1);
            for (int i = 2; i < log1.size(); i++)
                check("rep_rate", log1[i] - log1[i-1], 20);
        end

        // Masked repeat on left
        clear_stats();
        btn_raw[BTN_LEFT] = 1'b1;
        run(200);
        btn_raw[BTN_LEFT] = 1'b0;
        run(40);
        check("mask_count", pulse_cnt[BTN_LEFT], 1);

        // Simultaneous up and right
        clear_stats();
        btn_raw[BTN_UP] = 1'b1;
        btn_raw[BTN_RIGHT] = 1'b1;
        t0 = abs_cyc;
        run(30);
        btn_raw = '0;
        run(40);
        check("simul_same", first_pulse[BTN_UP], first_pulse[BTN_RIGHT]);
        check("simul_time", first_pulse[BTN_RIGHT] - t0, 22);

        // Reset asserted while down is auto-repeating
        clear_stats();
        btn_raw[BTN_DOWN] = 1'b1;
        run(100);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_level", int'(btn_level), 0);
        check("rst_async_pulse", int'(btn_pulse), 0);
        run(3);
        rst_n = 1'b1;
        clear_stats();
        t0 = abs_cyc;
        run(30);
        check("rst_fresh_first", first_pulse[BTN_DOWN] - t0, 22);
        check("rst_fresh_count", pulse_cnt[BTN_DOWN], 1);
        btn_raw = '0;
        run(40);

        // Random holds and glitches on all buttons
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                btn_raw = 5'($urandom_range(0, 31));
                hold = $urandom_range(1, 60);
            end
            step();
            hold--;
        end
        btn_raw = '0;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
